pagerank_iter_sched: RTL and testbench

- Iteration scheduler that sequences the pagerank compute stage (stream_start / stream_done / nextIteration / pagerank_complete) across a full run.
- Each iteration: fetches num_chunks stream beats from a partition memory through a req/ready address channel with in-order read return. Drives a beat-enable that top level uses to zero-gate the serial stream into the accumulator.
- Enforces iteration cap, wait-for-result timeout and abort with outstanding-read drain.

---
 rtl/pagerank_iter_sched.sv | 162 ++++++++++++++++
 tb/tb_pagerank_iter_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_iter_sched.sv
// Iteration scheduler for the pagerank compute stage: per-iteration partition
// fetch with bounded outstanding reads, result wait with cap/timeout, and abort drain.
module pagerank_iter_sched #(
  parameter int ADDR_W          = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_chunks,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       max_iterations,
  input  logic [31:0]       timeout_cycles,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  input  logic              rd_valid,
  output logic              beat_en,
  output logic              stream_start,
  output logic              stream_done,
  input  logic              next_iteration,
  input  logic              pagerank_complete,
  output logic              busy,
  output logic              run_done,
  output logic              max_hit,
  output logic              timed_out,
  output logic              protocol_err,
  output logic [31:0]       iter_count
);

  // Read channel: an address transfers on rd_req & rd_ready; data returns in
  // order, one beat per rd_valid, and is only meaningful while a read is outstanding.
  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_STREAM, S_CLOSE, S_WAIT, S_FINISH, S_DRAIN, S_ERROR
  } state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cfg_num, cfg_base, issue_addr;
  logic [31:0]       cfg_max, cfg_timeout, wait_cnt;
  logic [ADDR_W:0]   issued, returned;
  logic [3:0]        outstanding, out_nxt;
  logic              idle_like, valid_ok, issue_hs, start_acc;
  logic              iter_load, max_hit_set, timed_out_set;
  logic [31:0]       iter_inc;

  assign idle_like = (state == S_IDLE) || (state == S_ERROR);
  assign busy      = !idle_like;
  assign start_acc = idle_like && start;
  assign valid_ok  = rd_valid && (outstanding != 4'd0);
  assign rd_req    = (state == S_STREAM) && !abort && (issued < {1'b0, cfg_num})
                     && (outstanding < MAX_OUT);
  assign issue_hs  = rd_req && rd_ready;
  assign out_nxt   = outstanding + 4'(issue_hs) - 4'(valid_ok);
  assign rd_addr   = issue_addr;
  assign beat_en   = (state == S_STREAM) && valid_ok;
  assign stream_start = (state == S_KICK);
  assign stream_done  = (state == S_CLOSE);
  assign run_done  = (state == S_FINISH) && !abort;
  assign iter_inc  = iter_count + 32'd1;

  always_comb begin
    state_nxt     = state;
    iter_load     = 1'b0;
    max_hit_set   = 1'b0;
    timed_out_set = 1'b0;
    if (busy && abort && state != S_DRAIN) begin
      state_nxt = (out_nxt != 4'd0) ? S_DRAIN : S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ERROR: if (start) state_nxt = S_KICK;
        S_KICK:   state_nxt = (cfg_num == '0) ? S_CLOSE : S_STREAM;
        S_STREAM: if (valid_ok && (returned + (ADDR_W+1)'(1)) == {1'b0, cfg_num})
                    state_nxt = S_CLOSE;
        S_CLOSE:  state_nxt = S_WAIT;
        S_WAIT: begin
          // An input event in the final timeout cycle wins over the timeout.
          if (pagerank_complete) begin
            state_nxt = S_FINISH;
          end else if (next_iteration) begin
            iter_load = 1'b1;
            if (cfg_max != 32'd0 && iter_inc >= cfg_max) begin
              max_hit_set = 1'b1;
              state_nxt   = S_FINISH;
            end else begin
              state_nxt = S_KICK;
            end
          end else if (cfg_timeout != 32'd0 && wait_cnt == cfg_timeout - 32'd1) begin
            timed_out_set = 1'b1;
            state_nxt     = S_ERROR;
          end
        end
        S_FINISH: state_nxt = S_IDLE;
        S_DRAIN:  if (out_nxt == 4'd0) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_num      <= '0;
      cfg_base     <= '0;
      cfg_max      <= '0;
      cfg_timeout  <= '0;
      issue_addr   <= '0;
      issued       <= '0;
      returned     <= '0;
      outstanding  <= '0;
      wait_cnt     <= '0;
      iter_count   <= '0;
      max_hit      <= 1'b0;
      timed_out    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      if (start_acc) begin
        cfg_num     <= num_chunks;
        cfg_base    <= base_addr;
        cfg_max     <= max_iterations;
        cfg_timeout <= timeout_cycles;
        issue_addr  <= base_addr;
        issued      <= '0;
        returned    <= '0;
        wait_cnt    <= '0;
        iter_count  <= '0;
        max_hit     <= 1'b0;
        timed_out   <= 1'b0;
        protocol_err <= 1'b0;
      end else begin
        if (issue_hs) begin
          issue_addr <= issue_addr + ADDR_W'(1);
          issued     <= issued + (ADDR_W+1)'(1);
        end
        if (beat_en) returned <= returned + (ADDR_W+1)'(1);
        if (state == S_CLOSE) begin
          issued     <= '0;
          returned   <= '0;
          issue_addr <= cfg_base;
          wait_cnt   <= '0;
        end
        if (state == S_WAIT) wait_cnt <= wait_cnt + 32'd1;
        if (iter_load) iter_count <= iter_inc;
        if (max_hit_set) max_hit <= 1'b1;
        if (timed_out_set) timed_out <= 1'b1;
      end
      // A stray beat is flagged even in the cycle a new run starts.
      if (rd_valid && outstanding == 4'd0) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pagerank_iter_sched.sv
// Directed bench for pagerank_iter_sched: table-driven runs plus hand-written
// timeout, backpressure and abort/drain sequences against a latency-2 read model.
module tb_pagerank_iter_sched;
  localparam int ADDR_W = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start, abort;
  logic [ADDR_W-1:0] num_chunks, base_addr;
  logic [31:0]       max_iterations, timeout_cycles;
  logic              rd_req, rd_ready, rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              beat_en, stream_start, stream_done;
  logic              next_iteration, pagerank_complete;
  logic              busy, run_done, max_hit, timed_out, protocol_err;
  logic [31:0]       iter_count;

  pagerank_iter_sched #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .num_chunks(num_chunks), .base_addr(base_addr),
    .max_iterations(max_iterations), .timeout_cycles(timeout_cycles),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .beat_en(beat_en), .stream_start(stream_start), .stream_done(stream_done),
    .next_iteration(next_iteration), .pagerank_complete(pagerank_complete),
    .busy(busy), .run_done(run_done), .max_hit(max_hit), .timed_out(timed_out),
    .protocol_err(protocol_err), .iter_count(iter_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  logic [ADDR_W-1:0] exp_q[$];
  int pend_q[$];
  logic resp_en, force_valid;
  logic s_rd_req, s_beat, s_busy;
  int n_hs, n_beat, n_start, n_done, n_run_done, n_valid;
  int last_beat_cyc, last_start_cyc, last_done_cyc;

  typedef struct {
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] base;
    logic [31:0]       maxi;
    int                mode;   // 0 complete, 1 next_iteration, 2 both at once
    int                kicks;
    logic [31:0]       iter;
    logic              mhit;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic clear_stats();
    n_hs = 0; n_beat = 0; n_start = 0; n_done = 0; n_run_done = 0; n_valid = 0;
    last_beat_cyc = -1; last_start_cyc = -1; last_done_cyc = -1;
  endtask

  // One clock: sample at the falling edge, then drive the read model after the rising edge.
  task automatic cyc();
    @(negedge clock);
    s_rd_req = rd_req; s_beat = beat_en; s_busy = busy;
    if (rd_req && rd_ready) begin
      n_hs++;
      pend_q.push_back(cyc_n + 2);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_addr: got unexpected request 0x%0h expected none (cycle %0d)", rd_addr, cyc_n);
      end else begin
        check("rd_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
      end
    end
    if (rd_valid) n_valid++;
    if (beat_en) begin n_beat++; last_beat_cyc = cyc_n; end
    if (stream_start) begin n_start++; last_start_cyc = cyc_n; end
    if (stream_done) begin n_done++; last_done_cyc = cyc_n; end
    if (run_done) n_run_done++;
    if (stream_start || stream_done || beat_en)
      check("exclusive_pulses", 32'(int'(stream_start) + int'(stream_done) + int'(beat_en)), 32'd1);
    @(posedge clock);
    #1;
    cyc_n++;
    rd_valid = 1'b0;
    if (force_valid) begin
      rd_valid = 1'b1;
      force_valid = 1'b0;
    end else if (resp_en && pend_q.size() > 0 && pend_q[0] <= cyc_n) begin
      void'(pend_q.pop_front());
      rd_valid = 1'b1;
    end
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] n, input logic [ADDR_W-1:0] base,
                           input logic [31:0] maxi, input logic [31:0] tmo);
    num_chunks = n; base_addr = base; max_iterations = maxi; timeout_cycles = tmo;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push_addrs(input logic [ADDR_W-1:0] base, input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int j = 0; j < n; j++) begin
        logic [ADDR_W-1:0] a;
        a = base + ADDR_W'(j);
        exp_q.push_back(a);
      end
  endtask

  // Answer each stream_done in the first WAIT_RESULT cycle; stop at run_done.
  task automatic run_until_done(input int mode, input int budget, input int n);
    bit got = 1'b0;
    bit resp = 1'b0;
    int k = 0;
    while (!got && k < budget) begin
      int d0, r0;
      if (resp) begin
        pagerank_complete = (mode == 0 || mode == 2);
        next_iteration    = (mode == 1 || mode == 2);
        resp = 1'b0;
      end
      d0 = n_done; r0 = n_run_done;
      cyc();
      pagerank_complete = 1'b0;
      next_iteration = 1'b0;
      if (n_done != d0) begin
        resp = 1'b1;
        if (n == 0) check("close_after_kick", 32'(last_done_cyc - last_start_cyc), 32'd1);
        else        check("done_after_last_beat", 32'(last_done_cyc - last_beat_cyc), 32'd1);
      end
      if (n_run_done != r0) got = 1'b1;
      k++;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL run_timeout: got no run_done expected one within %0d cycles", budget);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{n: 16'd3, base: 16'h0010, maxi: 32'd0, mode: 0, kicks: 1, iter: 32'd0, mhit: 1'b0};
    vecs[1] = '{n: 16'd2, base: 16'h0020, maxi: 32'd2, mode: 1, kicks: 2, iter: 32'd2, mhit: 1'b1};
    vecs[2] = '{n: 16'd2, base: 16'hFFFF, maxi: 32'd0, mode: 0, kicks: 1, iter: 32'd0, mhit: 1'b0};
    vecs[3] = '{n: 16'd0, base: 16'h0040, maxi: 32'd0, mode: 0, kicks: 1, iter: 32'd0, mhit: 1'b0};
    vecs[4] = '{n: 16'd5, base: 16'h0100, maxi: 32'd3, mode: 1, kicks: 3, iter: 32'd3, mhit: 1'b1};
    vecs[5] = '{n: 16'd1, base: 16'h0080, maxi: 32'd0, mode: 2, kicks: 1, iter: 32'd0, mhit: 1'b0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_chunks = '0; base_addr = '0; max_iterations = '0; timeout_cycles = '0;
    rd_ready = 1'b1; rd_valid = 1'b0; next_iteration = 1'b0; pagerank_complete = 1'b0;
    resp_en = 1'b1; force_valid = 1'b0;
    clear_stats();

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_rd_req", 32'(rd_req), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'({stream_start, stream_done, beat_en, run_done}), 32'd0);
    check("reset_flags", 32'({max_hit, timed_out, protocol_err}), 32'd0);
    check("reset_iter_count", iter_count, 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc();

    // Table-driven complete runs.
    for (int v = 0; v < 6; v++) begin
      clear_stats();
      push_addrs(vecs[v].base, int'(vecs[v].n), vecs[v].kicks);
      start_run(vecs[v].n, vecs[v].base, vecs[v].maxi, 32'd0);
      run_until_done(vecs[v].mode, 400, int'(vecs[v].n));
      cyc();
      check($sformatf("v%0d_iter_count", v), iter_count, vecs[v].iter);
      check($sformatf("v%0d_max_hit", v), 32'(max_hit), 32'(vecs[v].mhit));
      check($sformatf("v%0d_beats", v), 32'(n_beat), 32'(int'(vecs[v].n) * vecs[v].kicks));
      check($sformatf("v%0d_kicks", v), 32'(n_start), 32'(vecs[v].kicks));
      check($sformatf("v%0d_closes", v), 32'(n_done), 32'(vecs[v].kicks));
      check($sformatf("v%0d_run_done", v), 32'(n_run_done), 32'd1);
      check($sformatf("v%0d_addrs_left", v), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_idle", v), 32'(s_busy), 32'd0);
    end

    // Timeout: no response after one beat, limit 5 cycles.
    begin
      int k;
      clear_stats();
      push_addrs(16'h0300, 1, 1);
      start_run(16'd1, 16'h0300, 32'd0, 32'd5);
      k = 0;
      while (n_done == 0 && k < 50) begin cyc(); k++; end
      k = 0;
      while (!timed_out && k < 20) begin cyc(); k++; end
      check("timeout_cycle", 32'(cyc_n - last_done_cyc), 32'd6);
      check("timeout_flag", 32'(timed_out), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_no_run_done", 32'(n_run_done), 32'd0);
      push_addrs(16'h0300, 1, 1);
      start_run(16'd1, 16'h0300, 32'd0, 32'd0);
      check("restart_clears_timed_out", 32'(timed_out), 32'd0);
      run_until_done(0, 100, 1);
    end

    // Backpressure: data withheld, outstanding limit stalls issue.
    begin
      clear_stats();
      push_addrs(16'h0200, 6, 1);
      resp_en = 1'b0;
      start_run(16'd6, 16'h0200, 32'd0, 32'd0);
      repeat (10) cyc();
      check("bp_issued_at_limit", 32'(n_hs), 32'd4);
      resp_en = 1'b1;
      cyc();
      cyc();
      check("bp_first_beat", 32'(s_beat), 32'd1);
      check("bp_req_still_low", 32'(s_rd_req), 32'd0);
      cyc();
      check("bp_req_resumes", 32'(s_rd_req), 32'd1);
      run_until_done(0, 200, 6);
      check("bp_beats", 32'(n_beat), 32'd6);
      check("bp_addrs_left", 32'(exp_q.size()), 32'd0);
    end

    // Abort with three reads outstanding, then a stray beat.
    begin
      int k;
      clear_stats();
      push_addrs(16'h0400, 3, 1);
      resp_en = 1'b0;
      start_run(16'd8, 16'h0400, 32'd0, 32'd0);
      k = 0;
      while (n_hs < 3 && k < 20) begin cyc(); k++; end
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      cyc();
      check("drain_rd_req", 32'(s_rd_req), 32'd0);
      check("drain_busy", 32'(s_busy), 32'd1);
      resp_en = 1'b1;
      k = 0;
      while (n_valid < 3 && k < 20) begin cyc(); k++; end
      cyc();
      check("drain_idle", 32'(s_busy), 32'd0);
      check("drain_no_beats", 32'(n_beat), 32'd0);
      check("abort_no_run_done", 32'(n_run_done), 32'd0);
      check("protocol_err_clear", 32'(protocol_err), 32'd0);
      force_valid = 1'b1;
      cyc();
      cyc();
      check("stray_no_beat", 32'(s_beat), 32'd0);
      check("stray_protocol_err", 32'(protocol_err), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
